// File: rtl/ode_mem_pkg.sv
// Shared constants and types for the ODE solver problem-memory subsystem.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ode_mem_pkg;

    localparam int ADDRESS_WIDTH       = 13;
    localparam int DATA_WIDTH          = 64;

    // Problem layout inside the RAM: A matrix from 0, then b vector, then x0.
    localparam int B_STARTING_ADDRESS  = 2507;
    localparam int X0_STARTING_ADDRESS = 5007;

    // Load-phase tracking of the RAM access arbiter.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        READY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Bundle of loader, solver and RAM signals around the RAM access arbiter.
// Latency: n/a (wiring only).
// Backpressure: loader has none (drops on overflow); solver holds Sv_Req until Sv_Grant.
// Ports: slave = arbiter side, master = environment side (loader, solver, RAM).
interface ram_access_arbiter_if #(
    parameter int AW = ode_mem_pkg::ADDRESS_WIDTH,
    parameter int DW = ode_mem_pkg::DATA_WIDTH
);
    // loader write stream
    logic          Ld_We;
    logic [AW-1:0] Ld_Address;
    logic [DW-1:0] Ld_Data;
    logic          Ld_Done;
    logic          Ld_Overflow;
    // solver access port
    logic          Sv_Req;
    logic          Sv_We;
    logic [AW-1:0] Sv_Address;
    logic [DW-1:0] Sv_Data;
    logic          Sv_Grant;
    logic          Sv_Rd_Valid;
    logic [DW-1:0] Sv_Rd_Data;
    // single-port RAM
    logic          RAM_We;
    logic [AW-1:0] RAM_Address;
    logic [DW-1:0] RAM_Data_Out;
    logic [DW-1:0] RAM_Data_In;
    // load phase
    logic          Load_Complete;

    modport slave (
        input  Ld_We, Ld_Address, Ld_Data, Ld_Done,
        input  Sv_Req, Sv_We, Sv_Address, Sv_Data,
        input  RAM_Data_In,
        output Ld_Overflow, Sv_Grant, Sv_Rd_Valid, Sv_Rd_Data,
        output RAM_We, RAM_Address, RAM_Data_Out, Load_Complete
    );

    modport master (
        output Ld_We, Ld_Address, Ld_Data, Ld_Done,
        output Sv_Req, Sv_We, Sv_Address, Sv_Data,
        output RAM_Data_In,
        input  Ld_Overflow, Sv_Grant, Sv_Rd_Valid, Sv_Rd_Data,
        input  RAM_We, RAM_Address, RAM_Data_Out, Load_Complete
    );

endinterface

// File: rtl/ram_write_fifo.sv
// Synchronous FIFO absorbing loader writes until the RAM port is free.
// Latency: 1 cycle push-to-head (no bypass); head is visible combinationally on dat_o.
// Backpressure: none upstream; a push into a full FIFO is accepted only with a same-edge pop.
// Ports: clk_i/rst_i (async active-high), push_i/dat_i in, pop_i in, dat_o head,
//        full_o/empty_o/count_o status.
module ram_write_fifo #(
    parameter int WIDTH = 77,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       dat_i,
    output logic [WIDTH-1:0]       dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dat_o   = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // The slot freed by a same-edge pop is reused, so a full FIFO still accepts.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= dat_i;
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port problem RAM between the loader write stream and the ODE solver.
// Latency: loader word reaches RAM >=1 cycle after Ld_We; solver grant is combinational,
//          read data valid the cycle after a read grant.
// Backpressure: loader cannot stall (buffered, dropped with sticky Ld_Overflow when full);
//               solver waits at most LD_BURST cycles behind buffered writes.
// Ports: CLK, RST (async active-high), bus (slave modport: loader, solver, RAM, Load_Complete).
module ram_access_arbiter #(
    parameter int ADDRESS_WIDTH = ode_mem_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = ode_mem_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH    = 4,
    parameter int LD_BURST      = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    ram_access_arbiter_if.slave  bus
);

    import ode_mem_pkg::*;

    localparam int EW = ADDRESS_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(LD_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(LD_BURST);

    logic [EW-1:0]            head_dat;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_data;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            count_d;
    logic                     empty_d;
    logic                     ld_pop;
    logic                     sv_grant;
    logic                     ld_accept;
    logic [BW-1:0]            burst_q;
    logic [BW-1:0]            burst_d;
    logic                     overflow_q;
    logic                     rd_valid_q;
    logic                     load_complete_q;
    arb_state_t               state_q;

    ram_write_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (bus.Ld_We),
        .pop_i   (ld_pop),
        .dat_i   ({bus.Ld_Address, bus.Ld_Data}),
        .dat_o   (head_dat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign {head_addr, head_data} = head_dat;

    // Buffered writes win unless the solver has already waited through a full burst.
    // RST gating keeps the RAM quiet for the whole reset pulse, not just after the flops clear.
    assign ld_pop    = ~RST & ~fifo_empty & ((burst_q < BURST_MAX) | ~bus.Sv_Req);
    assign sv_grant  = ~RST & ~ld_pop & bus.Sv_Req;
    assign ld_accept = bus.Ld_We & (~fifo_full | ld_pop);

    // Occupancy after this edge drives the load-phase transitions.
    assign count_d = fifo_count + CW'(ld_accept) - CW'(ld_pop);
    assign empty_d = (count_d == '0);

    always_comb begin
        burst_d = burst_q;
        if (sv_grant || !bus.Sv_Req) begin
            burst_d = '0;
        end else if (ld_pop && burst_q != BURST_MAX) begin
            burst_d = burst_q + BW'(1);
        end
    end

    assign bus.RAM_We        = ld_pop | (sv_grant & bus.Sv_We);
    assign bus.RAM_Address   = sv_grant ? bus.Sv_Address : head_addr;
    assign bus.RAM_Data_Out  = sv_grant ? bus.Sv_Data    : head_data;
    assign bus.Sv_Grant      = sv_grant;
    assign bus.Sv_Rd_Valid   = rd_valid_q;
    assign bus.Sv_Rd_Data    = bus.RAM_Data_In;
    assign bus.Ld_Overflow   = overflow_q;
    assign bus.Load_Complete = load_complete_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            burst_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            burst_q    <= burst_d;
            rd_valid_q <= sv_grant & ~bus.Sv_We;
            if (bus.Ld_We && !ld_accept) overflow_q <= 1'b1;
        end
    end

    // Load phase; Load_Complete is registered alongside the state it reflects.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= LOAD;
            load_complete_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.Ld_Done) begin
                        if (empty_d) begin
                            state_q         <= READY;
                            load_complete_q <= 1'b1;
                        end else begin
                            state_q         <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (empty_d) begin
                        state_q         <= READY;
                        load_complete_q <= 1'b1;
                    end
                end
                READY: begin
                    // A fresh problem load takes precedence over straggling writes.
                    if (!bus.Ld_Done) begin
                        state_q         <= LOAD;
                        load_complete_q <= 1'b0;
                    end else if (!empty_d) begin
                        state_q         <= DRAIN;
                        load_complete_q <= 1'b0;
                    end
                end
                default: begin
                    state_q         <= LOAD;
                    load_complete_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: directed loader/solver vectors,
// a queue-level reference model checked every cycle, and literal spot checks.
// Latency/backpressure: bench only.
module tb_ram_access_arbiter;

    import ode_mem_pkg::*;

    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int DEPTH = 4;
    localparam int BURST = 4;
    localparam logic [DW-1:0] B_WORD = 64'hDEADBEEF00002507;

    localparam int PH_LOAD  = 0;
    localparam int PH_DRAIN = 1;
    localparam int PH_READY = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    ram_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_access_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .LD_BURST      (BURST)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM with one-cycle synchronous read, read-before-write.
    logic [DW-1:0] ram [1<<AW];
    always @(posedge CLK) begin
        if (bus.RAM_We) ram[bus.RAM_Address] <= bus.RAM_Data_Out;
        bus.RAM_Data_In <= ram[bus.RAM_Address];
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    int            m_burst = 0;
    int            m_phase = PH_LOAD;
    bit            m_ovf   = 0;
    bit            m_rdv   = 0;
    logic [DW-1:0] m_rdd   = '0;
    logic [DW-1:0] mmem [1<<AW];

    task automatic mdl_reset();
        mq.delete();
        m_burst = 0;
        m_phase = PH_LOAD;
        m_ovf   = 0;
        m_rdv   = 0;
    endtask

    initial begin
        bit take, gnt, acc, n_rdv, n_ovf;
        int after, n_burst, n_phase;
        ent_t head, pushed;
        logic [DW-1:0] n_rdd;
        logic [AW-1:0] w_a;
        logic [DW-1:0] w_d;
        bit w_en;
        forever begin
            @(negedge CLK);
            if (RST) begin
                mdl_reset();
            end else begin
                take = (mq.size() > 0) && (m_burst < BURST || !bus.Sv_Req);
                gnt  = !take && bus.Sv_Req;
                head = (mq.size() > 0) ? mq[0] : '0;
                check1("m_grant", bus.Sv_Grant, gnt);
                if (take) begin
                    check1("m_ld_we", bus.RAM_We, 1'b1);
                    check64("m_ld_addr", 64'(bus.RAM_Address), 64'(head.a));
                    check64("m_ld_data", bus.RAM_Data_Out, head.d);
                end else if (gnt) begin
                    check1("m_sv_we", bus.RAM_We, bus.Sv_We);
                    check64("m_sv_addr", 64'(bus.RAM_Address), 64'(bus.Sv_Address));
                    if (bus.Sv_We) check64("m_sv_data", bus.RAM_Data_Out, bus.Sv_Data);
                end else begin
                    check1("m_idle_we", bus.RAM_We, 1'b0);
                end
                check1("m_overflow", bus.Ld_Overflow, m_ovf);
                check1("m_load_complete", bus.Load_Complete, m_phase == PH_READY);
                check1("m_rd_valid", bus.Sv_Rd_Valid, m_rdv);
                if (m_rdv) check64("m_rd_data", bus.Sv_Rd_Data, m_rdd);

                // What the next edge must do, from the current inputs.
                acc    = bus.Ld_We && (mq.size() < DEPTH || take);
                n_ovf  = m_ovf || (bus.Ld_We && !acc);
                pushed = '{a: bus.Ld_Address, d: bus.Ld_Data};
                after  = mq.size() - (take ? 1 : 0) + (acc ? 1 : 0);
                if (gnt || !bus.Sv_Req) n_burst = 0;
                else if (take)          n_burst = (m_burst + 1 > BURST) ? BURST : m_burst + 1;
                else                    n_burst = m_burst;
                n_rdv = gnt && !bus.Sv_We;
                n_rdd = mmem[bus.Sv_Address];
                w_en  = take || (gnt && bus.Sv_We);
                w_a   = take ? head.a : bus.Sv_Address;
                w_d   = take ? head.d : bus.Sv_Data;
                n_phase = m_phase;
                if (m_phase == PH_LOAD) begin
                    if (bus.Ld_Done) n_phase = (after == 0) ? PH_READY : PH_DRAIN;
                end else if (m_phase == PH_DRAIN) begin
                    if (after == 0) n_phase = PH_READY;
                end else begin
                    if (!bus.Ld_Done)   n_phase = PH_LOAD;
                    else if (after > 0) n_phase = PH_DRAIN;
                end

                @(posedge CLK);
                if (RST) begin
                    mdl_reset();
                end else begin
                    if (take) void'(mq.pop_front());
                    if (acc)  mq.push_back(pushed);
                    if (w_en) mmem[w_a] = w_d;
                    m_ovf   = n_ovf;
                    m_burst = n_burst;
                    m_rdv   = n_rdv;
                    m_rdd   = n_rdd;
                    m_phase = n_phase;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int gk;
        int waits;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]  = '0;
            mmem[i] = '0;
        end
        ram[B_STARTING_ADDRESS]  = B_WORD;
        mmem[B_STARTING_ADDRESS] = B_WORD;

        bus.Ld_We = 0; bus.Ld_Address = '0; bus.Ld_Data = '0; bus.Ld_Done = 0;
        bus.Sv_Req = 0; bus.Sv_We = 0; bus.Sv_Address = '0; bus.Sv_Data = '0;
        RST = 1;
        #2;
        check1("rst_ram_we", bus.RAM_We, 1'b0);
        check1("rst_grant", bus.Sv_Grant, 1'b0);
        check1("rst_load_complete", bus.Load_Complete, 1'b0);
        check1("rst_overflow", bus.Ld_Overflow, 1'b0);
        check1("rst_rd_valid", bus.Sv_Rd_Valid, 1'b0);
        step();
        step();
        RST = 0;

        // 1: sparse loader writes reach RAM exactly one cycle later, in order.
        for (int i = 0; i < 10; i++) begin
            bus.Ld_We = 1; bus.Ld_Address = AW'(i); bus.Ld_Data = 64'hA000 + 64'(i);
            #2;
            check1("t1_no_bypass", bus.RAM_We, 1'b0);
            step();
            bus.Ld_We = 0;
            #2;
            check1("t1_we_next", bus.RAM_We, 1'b1);
            check64("t1_addr_next", 64'(bus.RAM_Address), 64'(i));
            step();
        end
        check1("t1_no_overflow", bus.Ld_Overflow, 1'b0);

        // 2: continuous loader stream, solver read waits for at most BURST pops.
        gk = -1;
        waits = 0;
        for (int k = 0; k < 12; k++) begin
            bus.Ld_We = 1; bus.Ld_Address = AW'(100 + k); bus.Ld_Data = 64'hB000 + 64'(k);
            bus.Sv_Req = (k >= 1) && (gk < 0);
            bus.Sv_We = 0; bus.Sv_Address = AW'(B_STARTING_ADDRESS);
            #2;
            if (gk >= 0 && k == gk + 1) begin
                check1("t2_rd_valid", bus.Sv_Rd_Valid, 1'b1);
                check64("t2_rd_data", bus.Sv_Rd_Data, B_WORD);
            end
            if (bus.Sv_Req) begin
                if (bus.Sv_Grant) gk = k;
                else              waits++;
            end
            step();
        end
        check64("t2_grant_cycle", 64'(gk), 64'd5);
        check64("t2_wait_cycles", 64'(waits), 64'd4);
        bus.Ld_We = 0; bus.Sv_Req = 0;
        step(); step(); step();

        // 3: buffer fills behind solver grants; full+pop accepted, full without pop dropped.
        for (int a = 0; a < 21; a++) begin
            bus.Ld_We = 1; bus.Ld_Address = AW'(200 + a); bus.Ld_Data = 64'hC000 + 64'(a);
            bus.Sv_Req = 1; bus.Sv_We = 0; bus.Sv_Address = AW'(B_STARTING_ADDRESS);
            #2;
            if (a == 16) begin
                check1("t3_full_pop_we", bus.RAM_We, 1'b1);
                check1("t3_full_pop_nogrant", bus.Sv_Grant, 1'b0);
            end
            if (a == 20) begin
                check1("t3_capped_grant", bus.Sv_Grant, 1'b1);
                check1("t3_overflow_before", bus.Ld_Overflow, 1'b0);
            end
            step();
        end
        bus.Ld_We = 0; bus.Sv_Req = 0;
        #2;
        check1("t3_overflow_set", bus.Ld_Overflow, 1'b1);
        step();

        // 4: Ld_Done with 3 entries buffered -> DRAIN, 3 pops, READY.
        bus.Ld_Done = 1;
        for (int p = 0; p < 3; p++) begin
            #2;
            check1("t4_drain_lc", bus.Load_Complete, 1'b0);
            check1("t4_drain_we", bus.RAM_We, 1'b1);
            step();
        end
        #2;
        check1("t4_ready_lc", bus.Load_Complete, 1'b1);
        check1("t4_ready_idle", bus.RAM_We, 1'b0);
        check1("t4_overflow_sticky", bus.Ld_Overflow, 1'b1);

        // 5: write in READY -> DRAIN -> READY; Ld_Done low -> LOAD; empty Ld_Done -> READY.
        bus.Ld_We = 1; bus.Ld_Address = AW'(300); bus.Ld_Data = 64'h300;
        step();
        bus.Ld_We = 0;
        #2;
        check1("t5_drain_lc", bus.Load_Complete, 1'b0);
        check1("t5_drain_we", bus.RAM_We, 1'b1);
        check64("t5_drain_addr", 64'(bus.RAM_Address), 64'd300);
        step();
        #2;
        check1("t5_ready_again", bus.Load_Complete, 1'b1);
        bus.Ld_Done = 0;
        step();
        #2;
        check1("t5_back_to_load", bus.Load_Complete, 1'b0);
        bus.Ld_Done = 1;
        bus.Sv_Req = 1; bus.Sv_We = 1;
        bus.Sv_Address = AW'(X0_STARTING_ADDRESS); bus.Sv_Data = 64'h1234;
        #1;
        check1("t5_wr_grant", bus.Sv_Grant, 1'b1);
        check1("t5_wr_we", bus.RAM_We, 1'b1);
        check64("t5_wr_addr", 64'(bus.RAM_Address), 64'(X0_STARTING_ADDRESS));
        step();
        bus.Sv_We = 0;
        #2;
        check1("t5_ready_empty", bus.Load_Complete, 1'b1);
        check1("t5_rd_grant", bus.Sv_Grant, 1'b1);
        check1("t5_no_rdv_after_write", bus.Sv_Rd_Valid, 1'b0);
        step();
        bus.Sv_Req = 0;
        #2;
        check1("t5_rdv", bus.Sv_Rd_Valid, 1'b1);
        check64("t5_rd_data", bus.Sv_Rd_Data, 64'h1234);
        step();

        // 6: asynchronous reset mid-burst with 2 entries buffered.
        for (int a = 0; a < 7; a++) begin
            bus.Ld_We = 1; bus.Ld_Address = AW'(400 + a); bus.Ld_Data = 64'hD000 + 64'(a);
            bus.Sv_Req = 1; bus.Sv_We = 0; bus.Sv_Address = AW'(B_STARTING_ADDRESS);
            if (a < 6) step();
        end
        #2;
        check1("t6_pre_we", bus.RAM_We, 1'b1);
        check1("t6_pre_rdv", bus.Sv_Rd_Valid, 1'b1);
        check1("t6_pre_ovf", bus.Ld_Overflow, 1'b1);
        RST = 1;
        #1;
        check1("t6_rst_we", bus.RAM_We, 1'b0);
        check1("t6_rst_grant", bus.Sv_Grant, 1'b0);
        check1("t6_rst_lc", bus.Load_Complete, 1'b0);
        check1("t6_rst_ovf", bus.Ld_Overflow, 1'b0);
        check1("t6_rst_rdv", bus.Sv_Rd_Valid, 1'b0);
        bus.Ld_We = 0; bus.Sv_Req = 0; bus.Ld_Done = 0;
        step();
        step();
        RST = 0;
        bus.Sv_Req = 1;
        #2;
        check1("t6_empty_grant", bus.Sv_Grant, 1'b1);
        step();
        bus.Sv_Req = 0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
